walk_one_checker: RTL

Input-side counterpart of the walking-one pin exerciser on the iCEBreaker-bitsy test boards. It samples a vector of header pins driven by a second board or a loopback harness, synchronizes and filters it, and locks onto a one-hot pattern that advances one position per step. Once locked, any deviation is counted as an error. Lock and error status are shown on the board LEDs for bench bring-up of IO and wiring.

---
 rtl/walk_check_pkg.sv | 37 +++
 rtl/walk_sync_filter.sv | 59 +++++
 rtl/walk_one_checker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/walk_check_pkg.sv
// Shared types and helpers for the walking-one checker: FSM states, modulo step, one-hot decode.
package walk_check_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] idx;
  } onehot_t;

  // Step through a ring of n positions; n need not be a power of two.
  function automatic logic [31:0] mod_inc(input logic [31:0] v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

  function automatic onehot_t onehot_enc(input logic [MAX_W-1:0] w, input int unsigned npos);
    onehot_t     r;
    int unsigned ones;
    r    = '0;
    ones = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (w[i]) begin
        ones++;
        r.idx = i;
      end
    end
    r.valid = (ones == 1) && (r.idx < npos);
    return r;
  endfunction

endpackage

// File: rtl/walk_sync_filter.sv
// Two-flop pin synchronizer plus stability filter; emits the accepted word with a one-cycle strobe.
// WALK_CHECK_DEBOUNCE_EN selects the filter; without it every synchronized change is accepted.
module walk_sync_filter
  import walk_check_pkg::*;
#(
  parameter int WIDTH = 23
`ifdef WALK_CHECK_DEBOUNCE_EN
  , parameter int STABLE_CYCLES = 16
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] word,
  output logic             accept
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] last;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= '0;
      sync <= '0;
      last <= '0;
    end else begin
      meta <= pin;
      sync <= meta;
      if (accept) last <= sync;
    end
  end

`ifdef WALK_CHECK_DEBOUNCE_EN
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev <= '0;
      cnt  <= '0;
    end else begin
      prev <= sync;
      if (sync != prev) cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + 1'b1;
    end
  end

  // Comparing against the last accepted word keeps a long hold from re-firing.
  assign accept = (sync == prev) && (cnt >= CW'(STABLE_CYCLES - 1)) && (sync != last);
`else
  assign accept = (sync != last);
`endif

  assign word = sync;

endmodule

// File: rtl/walk_one_checker.sv
// Locks onto a walking-one pin pattern and counts sequence breaks while locked; drives status LEDs.
// Outputs registered one edge after the filter's accept strobe; WALK_CHECK_DEBOUNCE_EN enables the filter.
module walk_one_checker
  import walk_check_pkg::*;
#(
  parameter int WIDTH         = 23,
  parameter int NPOS          = 22,
  parameter int STABLE_CYCLES = 16,
  parameter int LOCK_COUNT    = 4,
  parameter int CNT_W         = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [WIDTH-1:0]         PIN_IN,
  input  logic                     CLEAR,
  output logic                     LOCKED,
  output logic                     ERR,
  output logic [CNT_W-1:0]         ERR_COUNT,
  output logic [$clog2(WIDTH)-1:0] POS,
  output logic                     LEDG_N,
  output logic                     LEDR_N
);

  localparam int PW = $clog2(WIDTH);
  localparam int EW = $clog2(NPOS);
  localparam int RW = $clog2(LOCK_COUNT + 1);

  logic [WIDTH-1:0] word;
  logic             acc;
  onehot_t          enc;
  logic             hit;
  logic [EW-1:0]    seed;

  state_t           state_q, state_d;
  logic [EW-1:0]    exp_q, exp_d;
  logic [RW-1:0]    run_q, run_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_hit;
  logic             locked_q;

  walk_sync_filter #(
    .WIDTH(WIDTH)
`ifdef WALK_CHECK_DEBOUNCE_EN
    , .STABLE_CYCLES(STABLE_CYCLES)
`endif
  ) u_filter (
    .CLK   (CLK),
    .RST_N (RST_N),
    .pin   (PIN_IN),
    .word  (word),
    .accept(acc)
  );

  assign enc  = onehot_enc(MAX_W'(word), NPOS);
  assign hit  = enc.valid && (enc.idx == 32'(exp_q));
  assign seed = EW'(mod_inc(enc.idx, NPOS));

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    pos_d   = pos_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    err_hit = 1'b0;
    if (acc) begin
      if (enc.valid) begin
        pos_d = PW'(enc.idx);
        exp_d = seed;
      end
      unique case (state_q)
        HUNT: begin
          if (enc.valid) begin
            state_d = TRACK;
            run_d   = RW'(1);
          end
        end
        TRACK: begin
          if (hit) begin
            run_d = run_q + 1'b1;
            if (run_q + 1'b1 == RW'(LOCK_COUNT)) state_d = LOCK;
          end else if (enc.valid) begin
            run_d = RW'(1);
          end else begin
            state_d = HUNT;
          end
        end
        LOCK: begin
          if (!hit) begin
            err_hit = 1'b1;
            run_d   = RW'(1);
            state_d = enc.valid ? TRACK : HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (err_hit) begin
      err_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    // A clear landing on the same edge as a break wins.
    if (CLEAR) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      run_q    <= '0;
      pos_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      locked_q <= (state_d == LOCK);
    end
  end

  assign LOCKED    = locked_q;
  assign ERR       = err_q;
  assign ERR_COUNT = cnt_q;
  assign POS       = pos_q;
  assign LEDG_N    = ~locked_q;
  assign LEDR_N    = ~err_q;

endmodule
